// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, frame shift-out on device
// clock falls, acknowledge check and a no-response timeout. Open-drain outputs.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [2:0]       clk_sync_q, clk_sync_d;
  logic [1:0]       data_sync_q, data_sync_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       bit_q, bit_d;
  logic [9:0]       word_q, word_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             fall;

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];

  always_comb begin
    clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    state_d     = state_q;
    inh_d       = inh_q;
    to_d        = to_q;
    bit_d       = bit_q;
    word_d      = word_q;
    clk_oe_d    = clk_oe_q;
    data_oe_d   = data_oe_q;
    err_d       = err_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (send) begin
          word_d   = {1'b1, ~^data_in, data_in};
          err_d    = 1'b0;
          inh_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          to_d      = '0;
          state_d   = S_REQ;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      S_REQ, S_SHIFT, S_ACK, S_WAIT: begin
        to_d = to_q + 1'b1;
        if (to_q == TO_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          case (state_q)
            S_REQ: if (fall) begin
              bit_d     = '0;
              data_oe_d = ~word_q[0];
              state_d   = S_SHIFT;
            end
            // The word shifts right each fall, so word_q[1] is always the next bit.
            S_SHIFT: if (fall) begin
              if (bit_q == 4'd9) begin
                data_oe_d = 1'b0;
                state_d   = S_ACK;
              end else begin
                bit_d     = bit_q + 1'b1;
                data_oe_d = ~word_q[1];
                word_d    = {1'b0, word_q[9:1]};
              end
            end
            S_ACK: if (fall) begin
              err_d   = data_sync_q[1];
              state_d = S_WAIT;
            end
            default: begin
              clk_oe_d  = 1'b0;
              data_oe_d = 1'b0;
              if (clk_sync_q[2] && data_sync_q[1]) begin
                done_d  = 1'b1;
                state_d = S_DONE;
              end
            end
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      inh_q       <= '0;
      to_q        <= '0;
      bit_q       <= '0;
      word_q      <= '0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      inh_q       <= inh_d;
      to_q        <= to_d;
      bit_q       <= bit_d;
      word_q      <= word_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      err_q       <= err_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus plus a PS/2 device model that clocks
// the frame, samples host data on rising clock and drives (or withholds) ack.
module tb_ps2_host_tx;

  localparam int unsigned INHIBIT = 5000;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned HALF    = 20;

  logic       clk = 1'b0;
  logic       clrn;
  logic       send;
  logic [7:0] data_in;
  logic       busy, done, err, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_pin, ps2_data_pin;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic        ack;
    logic [10:0] exp_frame;  // {stop, parity, data, start}, bit 0 first on wire
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INHIBIT),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk_pin),
    .ps2_data   (ps2_data_pin),
    .data_in    (data_in),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Accept a send, measure the inhibit length, check the release edge.
  task automatic start_txn(input logic [7:0] d);
    int n = 1;
    int g = 0;
    @(negedge clk);
    data_in = d;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    data_in = ~d;
    chk("accept_busy_oe", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'b110);
    chk("err_cleared", {31'd0, err}, 32'd0);
    while (g < 10000) begin
      @(negedge clk);
      g++;
      send = (g == 100);
      if (!ps2_clk_oe) break;
      n++;
    end
    send = 1'b0;
    chk("inhibit_len", n, INHIBIT);
    chk("release_edge", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'b01);
  endtask

  // Device: samples start before clocking, then one bit per clock pulse.
  // nbits=11 runs the full frame plus the two ack-phase pulses.
  task automatic device_frame(input int nbits, input logic ack, output logic [10:0] smp);
    smp = '0;
    repeat (10) @(negedge clk);
    smp[0] = ps2_data_pin;
    for (int k = 1; k < nbits; k++) begin
      dev_clk_low = 1'b1;
      if (k == 5 && nbits == 11) begin
        @(negedge clk);
        data_in = 8'hA5;
        send    = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk_low = 1'b0;
      smp[k] = ps2_data_pin;
      repeat (HALF) @(negedge clk);
    end
    if (nbits == 11) begin
      dev_data_low = ack;
      for (int p = 0; p < 2; p++) begin
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_clk_low = 1'b0;
        if (p == 0) repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
    end
  endtask

  task automatic finish_txn(input logic exp_err);
    int g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("err_at_done", {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    chk("post_done", {27'd0, busy, done, ps2_clk_oe, ps2_data_oe, err}, {27'd0, 4'b0000, exp_err});
  endtask

  task automatic run_vec(input vec_t v);
    logic [10:0] smp;
    start_txn(v.data);
    device_frame(11, v.ack, smp);
    chk("frame", {21'd0, smp}, {21'd0, v.exp_frame});
    finish_txn(v.exp_err);
  endtask

  initial begin
    logic [10:0] smp;
    vec_t        last;
    int          n;
    int          seen;

    clrn         = 1'b0;
    send         = 1'b0;
    data_in      = '0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    #2;
    chk("reset_outputs", {27'd0, busy, done, err, ps2_clk_oe, ps2_data_oe}, 32'd0);
    repeat (3) @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {27'd0, busy, done, err, ps2_clk_oe, ps2_data_oe}, 32'd0);

    vecs[0] = '{8'hED, 1'b1, 11'h7DA, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 11'h600, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 11'h7FE, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 11'h678, 1'b1};  // device withholds ack
    vecs[4] = '{8'hF3, 1'b1, 11'h7E6, 1'b0};
    vecs[5] = '{8'h01, 1'b1, 11'h402, 1'b0};
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Silent device: timeout counted from the clock release edge.
    start_txn(8'h12);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_outputs", {28'd0, done, err, ps2_clk_oe, ps2_data_oe}, 32'b1100);
    @(negedge clk);
    chk("timeout_idle", {30'd0, busy, done}, 32'd0);

    // Reset in the middle of the frame, after data bit 3 has been sampled.
    start_txn(8'h55);
    device_frame(5, 1'b0, smp);
    chk("partial_frame", {27'd0, smp[4:0]}, 32'b01010);
    chk("busy_mid_shift", {31'd0, busy}, 32'd1);
    dev_clk_low = 1'b1;
    @(negedge clk);
    #3 clrn = 1'b0;
    #1;
    chk("async_reset_release", {28'd0, busy, done, ps2_clk_oe, ps2_data_oe}, 32'd0);
    @(negedge clk);
    dev_clk_low = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    seen = 0;
    repeat (200) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_reset", seen, 0);

    last = '{8'hF4, 1'b1, 11'h5E8, 1'b0};
    run_vec(last);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1);
  end

endmodule
